display_scheduler: RTL

Sequences the shared 2-digit BCD 7-segment display between up to four measurement sources in the analyzer.
- Rotates through enabled sources on a page timer.
- Converts each 7-bit binary value to packed BCD with a multi-cycle double-dabble.
- Lets a one-shot alert request preempt the rotation for a longer hold.
- Output O_show_num feeds the display driver directly: high nibble is tens, low nibble is units; nibble codes above 9 blank the digit.

---
 rtl/display_scheduler_pkg.sv | 29 ++
 rtl/display_scheduler_if.sv | 21 ++
 rtl/display_scheduler_bin2bcd_seq.sv | 44 ++++
 rtl/display_scheduler.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/display_scheduler_pkg.sv
// Shared types and constants for the display scheduler slice.
// Also hosts the single double-dabble iteration used by the converter.
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    CONV,
    SHOW
  } state_e;

  localparam logic [7:0] C_BLANK       = 8'hFF;
  localparam logic [6:0] C_BCD_MAX     = 7'd99;
  localparam int         C_CONV_CYCLES = 7;

  // {tens, units, binary}: add-3 on nibbles >= 5, then shift left one
  function automatic logic [14:0] dabble_step(
    input logic [14:0] s
  );
    logic [14:0] t;
    t = s;
    if (t[10:7] > 4'd4)
      t[10:7] = t[10:7] + 4'd3;
    if (t[14:11] > 4'd4)
      t[14:11] = t[14:11] + 4'd3;
    return {t[13:0], 1'b0};
  endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Alert request/acknowledge handshake between the
// alert source and the display scheduler.
interface display_scheduler_if;

  logic       I_alert_req;
  logic [1:0] I_alert_src;
  logic       O_alert_ack;

  modport master (
    output I_alert_req,
    output I_alert_src,
    input  O_alert_ack
  );

  modport slave (
    input  I_alert_req,
    input  I_alert_src,
    output O_alert_ack
  );

endinterface

// File: rtl/display_scheduler_bin2bcd_seq.sv
// Sequential 7-bit binary to 2-digit packed BCD converter.
// One double-dabble iteration per cycle; done pulses after the last one.
module bin2bcd_seq
  import display_scheduler_pkg::*;
(
  input  logic       I_clk,
  input  logic       I_rst_n,
  input  logic       start,
  input  logic [6:0] din,
  output logic       done,
  output logic [7:0] bcd
);

  logic [14:0] sr_q;
  logic [2:0]  cnt_q;
  logic        run_q;

  // the start edge already performs the first iteration
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr_q  <= dabble_step({8'd0, din});
        cnt_q <= 3'd1;
        run_q <= 1'b1;
      end else if (run_q) begin
        sr_q  <= dabble_step(sr_q);
        cnt_q <= cnt_q + 3'd1;
        if (cnt_q == 3'(C_CONV_CYCLES - 1)) begin
          run_q <= 1'b0;
          done  <= 1'b1;
        end
      end
    end
  end

  assign bcd = sr_q[14:7];

endmodule

// File: rtl/display_scheduler.sv
// Rotates the shared 2-digit BCD display across enabled sources,
// with one-shot alert preemption and a longer alert hold.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int C_NUM_SRC     = 4,
  parameter int C_PAGE_TICKS  = 50_000_000,
  parameter int C_ALERT_TICKS = 150_000_000
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic [7*C_NUM_SRC-1:0] I_src_value,
  input  logic [C_NUM_SRC-1:0]   I_src_en,
  input  logic                   I_freeze,
  display_scheduler_if.slave     alert,
  output logic [7:0]             O_show_num,
  output logic [1:0]             O_page,
  output logic                   O_busy
);

  state_e      state_q, state_d;
  logic [1:0]  page_q, page_d;
  logic [7:0]  show_q, show_d;
  logic [1:0]  sel_q, sel_d;
  logic        sel_ok_q, sel_ok_d;
  logic        alert_q, alert_d;
  logic        ack_q, ack_d;
  logic [31:0] timer_q, timer_d;

  logic        conv_start;
  logic        conv_done;
  logic [7:0]  conv_bcd;

  logic [1:0]  first_idx;
  logic        first_ok;
  logic [1:0]  next_idx;
  logic        next_ok;
  logic [6:0]  sel_val;
  logic        accept;
  logic        counting;
  logic        expire;
  logic [31:0] hold_last;

  bin2bcd_seq u_conv (
    .I_clk   (I_clk),
    .I_rst_n (I_rst_n),
    .start   (conv_start),
    .din     (sel_val),
    .done    (conv_done),
    .bcd     (conv_bcd)
  );

  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    for (int i = C_NUM_SRC - 1; i >= 0; i--) begin
      if (I_src_en[i]) begin
        first_idx = 2'(i);
        first_ok  = 1'b1;
      end
    end
  end

  // descending scan so the nearest index above the page wins
  always_comb begin
    int j;
    j        = 0;
    next_idx = page_q;
    next_ok  = 1'b0;
    for (int i = C_NUM_SRC; i >= 1; i--) begin
      j = (int'(page_q) + i) % C_NUM_SRC;
      if (I_src_en[j]) begin
        next_idx = 2'(j);
        next_ok  = 1'b1;
      end
    end
  end

  // an out-of-range selection reads as over-range and blanks
  always_comb begin
    sel_val = 7'h7F;
    for (int k = 0; k < C_NUM_SRC; k++) begin
      if (sel_ok_q && sel_q == 2'(k))
        sel_val = I_src_value[7*k +: 7];
    end
  end

  assign accept = alert.I_alert_req && !alert_q
               && (state_q == IDLE || state_q == SHOW);

  assign hold_last = alert_q ? 32'(C_ALERT_TICKS - 1)
                             : 32'(C_PAGE_TICKS - 1);

  assign counting = alert_q || !I_freeze;
  assign expire   = counting && (timer_q == hold_last);

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    show_d     = show_q;
    sel_d      = sel_q;
    sel_ok_d   = sel_ok_q;
    alert_d    = alert_q;
    ack_d      = 1'b0;
    timer_d    = timer_q;
    conv_start = 1'b0;

    unique case (state_q)
      IDLE: begin
        show_d = C_BLANK;
        if (!accept && first_ok) begin
          sel_d    = first_idx;
          sel_ok_d = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        page_d = sel_q;
        if (sel_val > C_BCD_MAX) begin
          show_d  = C_BLANK;
          timer_d = '0;
          state_d = SHOW;
        end else begin
          conv_start = 1'b1;
          state_d    = CONV;
        end
      end
      CONV: begin
        if (conv_done) begin
          show_d  = conv_bcd;
          timer_d = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        if (!accept) begin
          if (expire) begin
            alert_d = 1'b0;
            if (next_ok) begin
              sel_d    = next_idx;
              sel_ok_d = 1'b1;
              state_d  = LOAD;
            end else begin
              show_d  = C_BLANK;
              state_d = IDLE;
            end
          end else if (counting) begin
            timer_d = timer_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      ack_d    = 1'b1;
      alert_d  = 1'b1;
      sel_d    = alert.I_alert_src;
      sel_ok_d = int'(alert.I_alert_src) < C_NUM_SRC;
      state_d  = LOAD;
    end
  end

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q  <= IDLE;
      page_q   <= '0;
      show_q   <= C_BLANK;
      sel_q    <= '0;
      sel_ok_q <= 1'b0;
      alert_q  <= 1'b0;
      ack_q    <= 1'b0;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      show_q   <= show_d;
      sel_q    <= sel_d;
      sel_ok_q <= sel_ok_d;
      alert_q  <= alert_d;
      ack_q    <= ack_d;
      timer_q  <= timer_d;
    end
  end

  assign O_show_num        = show_q;
  assign O_page            = page_q;
  assign O_busy            = (state_q == LOAD) || (state_q == CONV);
  assign alert.O_alert_ack = ack_q;

endmodule
